// File: rtl/dsp_result_collector_if.sv
// Result stream bundle between the DSP result input, the collector and its consumer.
// Latency: none; this is wiring only.
// Backpressure: m_ready stalls the output side; the input side cannot be stalled.
interface dsp_result_collector_if #(
    parameter int WIDTH           = 16,
    parameter int OUT_WIDTH       = 16,
    parameter int POST_SHIFT_BITS = 4,
    parameter int LEVEL_BITS      = 3
);
    logic                       in_valid;
    logic [2*WIDTH-1:0]         in_data;
    logic [POST_SHIFT_BITS-1:0] post_shift;
    logic                       m_valid;
    logic                       m_ready;
    logic [OUT_WIDTH-1:0]       m_data;
    logic                       m_sat;
    logic [LEVEL_BITS-1:0]      level;
    logic                       overflow;
    logic                       ovf_clr;

    // Environment side: drives DSP results and consumer handshake.
    modport master (
        output in_valid, in_data, post_shift, m_ready, ovf_clr,
        input  m_valid, m_data, m_sat, level, overflow
    );

    // Collector side.
    modport slave (
        input  in_valid, in_data, post_shift, m_ready, ovf_clr,
        output m_valid, m_data, m_sat, level, overflow
    );
endinterface

// File: rtl/dsp_result_collector.sv
// Shifts, narrows and buffers DSP results into a DEPTH-entry FIFO; optional saturation via COLLECTOR_SAT_EN.
// Latency: one cycle from in_valid to m_valid on an empty FIFO; no combinational in-to-out path.
// Backpressure: m_ready stalls the head; input is never stalled, so a result arriving while full is dropped and overflow is set stickily.
module dsp_result_collector #(
    parameter int WIDTH           = 16,
    parameter int OUT_WIDTH       = 16,
    parameter int POST_SHIFT_BITS = 4,
    parameter int DEPTH           = 4,
    parameter int LEVEL_BITS      = 3
) (
    input logic                  clk,
    input logic                  rst,
    dsp_result_collector_if.slave bus
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [LEVEL_BITS-1:0] FULL_LEVEL = LEVEL_BITS'(DEPTH);

    logic [POST_SHIFT_BITS-1:0] shamt;
    logic signed [2*WIDTH-1:0]  shifted;
    logic [OUT_WIDTH-1:0]       narrow;
    logic                       narrow_sat;

    logic [OUT_WIDTH-1:0]  mem_data [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [LEVEL_BITS-1:0] level_q;
    logic                  overflow_q;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign shamt   = bus.post_shift;
    assign shifted = $signed(bus.in_data) >>> shamt;

`ifdef COLLECTOR_SAT_EN
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = {OUT_WIDTH{1'b1}} >> 1;
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic mem_sat [DEPTH];

    // Clip to the signed OUT_WIDTH range when the discarded high bits are not a pure sign extension.
    always_comb begin
        narrow     = shifted[OUT_WIDTH-1:0];
        narrow_sat = 1'b0;
        if (!(&shifted[2*WIDTH-1:OUT_WIDTH-1]) && (|shifted[2*WIDTH-1:OUT_WIDTH-1])) begin
            narrow_sat = 1'b1;
            narrow     = shifted[2*WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Saturation flag travels with its entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_sat[wr_ptr] <= narrow_sat;
        end
    end

    assign bus.m_sat = mem_sat[rd_ptr];
`else
    logic unused_shift_bits;

    // Plain two's-complement wrap: keep the low OUT_WIDTH bits.
    always_comb begin
        narrow     = shifted[OUT_WIDTH-1:0];
        narrow_sat = 1'b0;
    end

    assign unused_shift_bits = ^{shifted, narrow_sat};
    assign bus.m_sat         = 1'b0;
`endif

    assign full = (level_q == FULL_LEVEL);
    assign pop  = bus.m_valid && bus.m_ready;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;

    // Storage array; contents need no reset since validity is tracked by level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= narrow;
        end
    end

    // Pointers, occupancy and sticky overflow; a drop in the clear cycle keeps overflow set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.m_valid  = (level_q != '0);
    assign bus.m_data   = mem_data[rd_ptr];
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
endmodule
